// File: rtl/imu_frame_pkg.sv
// imu_frame_pkg: shared types and constants for the IMU frame assembler (IMU_BIAS_SUB_EN selects bias subtraction in the top)
package imu_frame_pkg;
    localparam int N_AXES     = 6;
    localparam int FIFO_DEPTH = 2;
    localparam int SEQ_MAX_W  = 32;

    typedef enum logic [2:0] {
        AX_GX,
        AX_GY,
        AX_GZ,
        AX_AX,
        AX_AY,
        AX_AZ
    } axis_e;

    typedef enum logic [1:0] {
        F_EMPTY,
        F_ONE,
        F_FULL
    } fifo_state_e;

    typedef struct packed {
        logic [SEQ_MAX_W-1:0] seq;
        logic signed [15:0]   az;
        logic signed [15:0]   ay;
        logic signed [15:0]   ax;
        logic signed [15:0]   gz;
        logic signed [15:0]   gy;
        logic signed [15:0]   gx;
    } frame_t;
endpackage

// File: rtl/frame_fifo2.sv
// frame_fifo2: two-entry frame FIFO, head always in mem0 so the output is a plain register
module frame_fifo2
    import imu_frame_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  frame_t din,
    output frame_t dout,
    output logic   full,
    output logic   empty
);
    fifo_state_e state_q, state_d;
    frame_t      mem0_q, mem0_d, mem1_q, mem1_d;

    // state and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_EMPTY;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            state_q <= state_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end

    // next state and storage; a push into FULL without a pop is ignored here, the caller flags it
    always_comb begin
        state_d = state_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        case (state_q)
            F_EMPTY: begin
                if (push) begin
                    mem0_d  = din;
                    state_d = F_ONE;
                end
            end
            F_ONE: begin
                if (push && pop) begin
                    mem0_d = din;
                end else if (pop) begin
                    state_d = F_EMPTY;
                end else if (push) begin
                    mem1_d  = din;
                    state_d = F_FULL;
                end
            end
            F_FULL: begin
                if (pop) begin
                    mem0_d = mem1_q;
                    if (push) mem1_d = din;
                    else state_d = F_ONE;
                end
            end
            default: state_d = F_EMPTY;
        endcase
    end

    assign dout  = mem0_q;
    assign full  = state_q == F_FULL;
    assign empty = state_q == F_EMPTY;
endmodule

// File: rtl/imu_frame_assembler.sv
// imu_frame_assembler: collects six IMU words into a frame and queues it for the filter; IMU_BIAS_SUB_EN adds per-axis bias subtraction
module imu_frame_assembler
    import imu_frame_pkg::*;
#(
    parameter int SEQ_W = 8
) (
    input  logic             rp2350_sck,
    input  logic             rp2350_rst_n,
    input  logic [15:0]      word_in,
    input  logic             word_valid,
    input  logic             frame_sync,
`ifdef IMU_BIAS_SUB_EN
    input  logic [95:0]      bias_in,
`endif
    output logic [95:0]      frame_data,
    output logic [SEQ_W-1:0] frame_seq,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             ovf,
    input  logic             ovf_clr
);
    axis_e                     idx_q, idx_d, cur_idx;
    logic                      cap_en;
    logic [N_AXES-2:0][15:0]   slot;
    logic [15:0]               word_st;
    logic [SEQ_W-1:0]          seq_cnt;
    logic                      push_req, pop, drop, full, empty;
    frame_t                    push_frame, head;

    // a sync pulse restarts the burst, and a word captured on that edge lands in gx
    always_comb begin
        cur_idx  = frame_sync ? AX_GX : idx_q;
        idx_d    = cap_en ? (cur_idx == AX_AZ ? AX_GX : axis_e'(cur_idx + 3'd1)) : cur_idx;
        push_req = cap_en && cur_idx == AX_AZ;
    end

`ifdef IMU_BIAS_SUB_EN
    logic [15:0] bias_sel;
    logic [16:0] diff;

    // subtract the bias of the axis being captured, clamping to the signed 16-bit range
    always_comb begin
        bias_sel = bias_in[{cur_idx, 4'b0} +: 16];
        diff     = {word_in[15], word_in} - {bias_sel[15], bias_sel};
        word_st  = (diff[16] ^ diff[15]) ? (diff[16] ? 16'h8000 : 16'h7FFF) : diff[15:0];
    end
`else
    // raw word goes straight into the frame
    always_comb word_st = word_in;
`endif

    // the sixth word bypasses the slots so the frame is pushed on its capture edge
    always_comb begin
        push_frame     = '0;
        push_frame.gx  = slot[0];
        push_frame.gy  = slot[1];
        push_frame.gz  = slot[2];
        push_frame.ax  = slot[3];
        push_frame.ay  = slot[4];
        push_frame.az  = word_st;
        push_frame.seq = SEQ_MAX_W'(seq_cnt);
    end

    assign pop         = frame_valid && frame_ready;
    assign drop        = push_req && full && !pop;
    assign frame_valid = !empty;
    assign frame_data  = {head.az, head.ay, head.ax, head.gz, head.gy, head.gx};
    assign frame_seq   = SEQ_W'(head.seq);

    // capture pipeline, axis index and assembly slots
    always_ff @(posedge rp2350_sck or negedge rp2350_rst_n) begin
        if (!rp2350_rst_n) begin
            cap_en <= 1'b0;
            idx_q  <= AX_GX;
            slot   <= '0;
        end else begin
            cap_en <= word_valid;
            idx_q  <= idx_d;
            if (cap_en && cur_idx != AX_AZ) slot[cur_idx] <= word_st;
        end
    end

    // sequence counter advances only on frames the FIFO accepts; a drop beats a clear
    always_ff @(posedge rp2350_sck or negedge rp2350_rst_n) begin
        if (!rp2350_rst_n) begin
            seq_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push_req && !drop) seq_cnt <= seq_cnt + 1'b1;
            ovf <= drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
        end
    end

    frame_fifo2 u_fifo (
        .clk   (rp2350_sck),
        .rst_n (rp2350_rst_n),
        .push  (push_req && !drop),
        .pop   (pop),
        .din   (push_frame),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: doc/imu_frame_assembler.md
IMU_FRAME_ASSEMBLER -- requirements
Module: imu_frame_assembler

Interface
REQ-001 SHALL have parameter SEQ_W, default 8, width of the frame sequence counter.
REQ-002 SHALL have port rp2350_sck  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rp2350_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port word_in  input  16  signed big-endian word from the SPI deserializer.
REQ-005 SHALL have port word_valid  input  1  one-cycle pulse; word_in is stable on the cycle after the pulse.
REQ-006 SHALL have port frame_sync  input  1  one-cycle pulse realigning the axis index to 0.
REQ-007 SHALL have port frame_data  output  96  {az,ay,ax,gz,gy,gx}, gx in bits [15:0].
REQ-008 SHALL have port frame_seq  output  SEQ_W  sequence number of the frame at the FIFO head.
REQ-009 SHALL have ports frame_valid output 1 and frame_ready input 1: valid/ready handshake to the filter.
REQ-010 SHALL have ports ovf output 1 (sticky drop flag) and ovf_clr input 1 (clears ovf).

Function
REQ-011 SHALL register word_valid once (cap_en) and capture word_in on the edge where cap_en is high.
REQ-012 SHALL keep a 3-bit axis index 0..5: gx,gy,gz,ax,ay,az (ISM330DHCX burst order from OUTX_L_G).
REQ-013 SHALL store each captured word into the assembly slot for the current index, then increment the index; 5 wraps to 0.
REQ-014 SHALL push the assembled frame and the current seq count into the output FIFO on the edge capturing index 5.
REQ-015 SHALL increment the seq counter modulo 2^SEQ_W on every accepted push only.
REQ-016 SHALL, on frame_sync, discard the partial frame and set index to 0; if a capture coincides, that word is stored as index 0 and index becomes 1.
REQ-017 SHALL implement a 2-entry FIFO with states EMPTY, ONE, FULL; push+pop in ONE stays ONE; pop in FULL with push stays FULL.
REQ-018 SHALL assert frame_valid whenever FIFO is not EMPTY; pop occurs on an edge where frame_valid and frame_ready are both high.
REQ-019 SHALL present frame_valid high on the cycle after the index-5 capture edge when the FIFO was EMPTY (latency 1).
REQ-020 SHALL hold frame_data and frame_seq stable while frame_valid high and frame_ready low.
REQ-021 SHALL, on push while FULL without simultaneous pop, drop the new frame, not increment seq, and set ovf.
REQ-022 SHALL clear ovf on ovf_clr unless a drop occurs the same cycle (set wins).

Reset
REQ-023 SHALL on rp2350_rst_n low immediately clear: index 0, cap_en 0, FIFO EMPTY, frame_valid 0, frame_data 0, frame_seq 0, ovf 0, seq counter 0.
REQ-024 SHALL discard any partial frame on reset mid-burst; the first post-reset capture is index 0.

Configuration
REQ-025 SHALL with IMU_BIAS_SUB_EN defined add input bias_in [95:0] (same packing as frame_data) and store word_in minus the per-axis bias, saturated to [-32768, 32767].
REQ-026 SHALL without IMU_BIAS_SUB_EN omit bias_in and store word_in unmodified; latency identical in both builds.

Structure
REQ-027 SHALL place axis enum, N_AXES=6, FIFO_DEPTH=2, and packed struct frame_t (six signed 16-bit axes plus seq) in package imu_frame_pkg.
REQ-028 SHALL implement the FIFO as sub-module frame_fifo2 (frame_t data, push/pop/full/empty).

Verification
REQ-029 SHALL test: six words 0x0001..0x0006, frame_ready=1 -> one frame, frame_data=0x000600050004000300020001, seq=0, valid one cycle after 6th capture.
REQ-030 SHALL test: frame_ready=0, three full frames -> frames seq 0,1 held, third dropped, ovf=1; next accepted frame seq=2.
REQ-031 SHALL test: three words, then frame_sync, then six words 0x0010..0x0015 -> single frame containing only 0x0010..0x0015.
REQ-032 SHALL test: FIFO FULL, pop and index-5 push same edge -> stays FULL, no drop, ovf=0.
REQ-033 SHALL test: reset asserted after four words -> outputs zero asynchronously; next six words form seq 0 frame.
REQ-034 SHALL test (IMU_BIAS_SUB_EN): word 0x8005 with bias 0x0010 -> stored 0x8000 (saturated); word 0x0100 bias 0x0010 -> 0x00F0.
